// File: rtl/spi_word_deserializer_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_word_deserializer_if
// Brief    : Raw SPI pins plus the word valid/ready handshake and status of
//            the SPI word deserializer.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_word_deserializer_if #(
  parameter int WIDTH = 16
);
  logic                     sck;
  logic                     sdi;
  logic                     load;
  logic [WIDTH-1:0]         out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     overrun;
  logic [$clog2(WIDTH)-1:0] bit_count;

  // Deserializer side: receives pins and ready, produces words and status
  modport slave (
    input  sck, sdi, load, out_ready,
    output out_data, out_valid, overrun, bit_count
  );

  // Environment side: drives pins and ready, consumes words and status
  modport master (
    output sck, sdi, load, out_ready,
    input  out_data, out_valid, overrun, bit_count
  );
endinterface
`default_nettype wire

// File: rtl/spi_word_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : spi_word_deserializer
// Brief    : Oversampling SPI receiver. Synchronises sck/sdi/load into clk,
//            assembles WIDTH-bit words in the configured bit order and hands
//            them out over valid/ready with a sticky overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
module spi_word_deserializer #(
  parameter int WIDTH     = 16,
  parameter bit LSB_FIRST = 1'b1,
  parameter bit CPOL      = 1'b0
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  spi_word_deserializer_if.slave    bus
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // First synchroniser stage for {load, sdi, sck}
  logic [2:0]       meta_q, meta_d;
  // Second stage for {sdi, sck}; the second load stage is the FSM state
  logic [1:0]       sync_q, sync_d;
  logic             sck_dly_q, sck_dly_d;
  logic [0:0]       state_q, state_d;

  // Only WIDTH-1 partial bits are kept: the bit that would be shifted out on
  // completion is never needed, and the final bit goes straight to out_data.
  logic [WIDTH-2:0] sr_q, sr_d;
  logic [CW-1:0]    bit_count_q, bit_count_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;

  logic             w_sck_s;
  logic             w_sdi_s;
  logic             w_strobe;
  logic             w_shift_en;
  logic             w_clear;
  logic             w_complete;
  logic [WIDTH-1:0] w_shifted;

  assign w_sck_s = sync_q[0];
  assign w_sdi_s = sync_q[1];

  // Sampling edge detect on the synchronised clock
  generate
    if (CPOL) begin : g_cpol1
      assign w_strobe = ~w_sck_s & sck_dly_q;
    end else begin : g_cpol0
      assign w_strobe = w_sck_s & ~sck_dly_q;
    end
  endgenerate

  // Post-shift word: sdi enters at the top (LSB-first) or bottom (MSB-first)
  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign w_shifted = {w_sdi_s, sr_q};
    end else begin : g_msb_first
      assign w_shifted = {sr_q, w_sdi_s};
    end
  endgenerate

  // Synchroniser chain and sck delay tap
  always_comb begin
    meta_d    = {bus.load, bus.sdi, bus.sck};
    sync_d    = meta_q[1:0];
    sck_dly_d = w_sck_s;
  end

  // FSM next state: SHIFT exactly while the synchronised load is high
  always_comb begin
    state_d = ST_IDLE;
    if (meta_q[2]) begin
      state_d = ST_SHIFT;
    end
  end

  // FSM outputs: IDLE clears the partial word, SHIFT accepts strobes
  always_comb begin
    w_clear    = 1'b0;
    w_shift_en = 1'b0;
    case (state_q)
      ST_IDLE:  w_clear    = 1'b1;
      ST_SHIFT: w_shift_en = w_strobe;
      default:  w_clear    = 1'b1;
    endcase
  end

  assign w_complete = w_shift_en && (bit_count_q == LAST_BIT);

  // Shift register, bit counter and output handshake
  always_comb begin
    sr_d        = sr_q;
    bit_count_d = bit_count_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (w_clear) begin
      sr_d        = '0;
      bit_count_d = '0;
    end else if (w_shift_en) begin
      if (LSB_FIRST) begin
        sr_d = w_shifted[WIDTH-1:1];
      end else begin
        sr_d = w_shifted[WIDTH-2:0];
      end
      if (w_complete) begin
        bit_count_d = '0;
        // A pending word may only be replaced if it transfers this cycle
        if (!out_valid_q || bus.out_ready) begin
          out_data_d  = w_shifted;
          out_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        bit_count_d = bit_count_q + CW'(1);
      end
    end
  end

  // State register for synchronisers, FSM and datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q      <= '0;
      sync_q      <= '0;
      sck_dly_q   <= 1'b0;
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      bit_count_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      meta_q      <= meta_d;
      sync_q      <= sync_d;
      sck_dly_q   <= sck_dly_d;
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_count_q <= bit_count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.bit_count = bit_count_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_word_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_word_deserializer
// Brief    : Scoreboard bench for two deserializer instances:
//            A = 16-bit LSB-first CPOL0, B = 8-bit MSB-first CPOL1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_word_deserializer;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bit sck_v [2];
  bit sdi_v [2];
  bit load_v[2];
  bit rdy_v [2];

  int width_c[2] = '{16, 8};
  bit lsb_c  [2] = '{1'b1, 1'b0};
  bit cpol_c [2] = '{1'b0, 1'b1};

  spi_word_deserializer_if #(.WIDTH(16)) ifa();
  spi_word_deserializer_if #(.WIDTH(8))  ifb();

  assign ifa.sck = sck_v[0];  assign ifa.sdi = sdi_v[0];
  assign ifa.load = load_v[0]; assign ifa.out_ready = rdy_v[0];
  assign ifb.sck = sck_v[1];  assign ifb.sdi = sdi_v[1];
  assign ifb.load = load_v[1]; assign ifb.out_ready = rdy_v[1];

  spi_word_deserializer #(.WIDTH(16), .LSB_FIRST(1'b1), .CPOL(1'b0)) u_a (
    .clk(clk), .reset(reset), .bus(ifa.slave));
  spi_word_deserializer #(.WIDTH(8), .LSB_FIRST(1'b0), .CPOL(1'b1)) u_b (
    .clk(clk), .reset(reset), .bus(ifb.slave));

  int vectors     = 0;
  int miscompares = 0;
  logic [15:0] qa[$];
  logic [7:0]  qb[$];
  int vcnt[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One SPI bit: non-sampling phase carries the new data, then the sampling
  // edge. With pulse set, out_ready is high only in the cycle the word
  // completes (the cycle before the third clk edge after the sampling edge).
  task automatic send_bit(input int inst, input bit b, input int half, input bit pulse);
    sck_v[inst] = cpol_c[inst];
    sdi_v[inst] = b;
    repeat (half) tick();
    sck_v[inst] = ~cpol_c[inst];
    if (pulse) begin
      tick(); tick();
      rdy_v[inst] = 1'b1;
      tick();
      rdy_v[inst] = 1'b0;
      repeat (half - 3) tick();
    end else begin
      repeat (half) tick();
    end
  endtask

  task automatic send_word(input int inst, input logic [31:0] w, input int nbits,
                           input int half, input bit pulse_last);
    logic [31:0] wv;
    int idx;
    wv = w;
    for (int i = 0; i < nbits; i++) begin
      idx = lsb_c[inst] ? i : (width_c[inst] - 1 - i);
      send_bit(inst, wv[idx], half, pulse_last && (i == nbits - 1));
    end
  endtask

  task automatic frame_start(input int inst);
    sck_v[inst]  = cpol_c[inst];
    load_v[inst] = 1'b1;
    repeat (4) tick();
  endtask

  task automatic frame_end(input int inst);
    sck_v[inst] = cpol_c[inst];
    repeat (2) tick();
    load_v[inst] = 1'b0;
    repeat (4) tick();
  endtask

  // Monitor A: every transfer must match the oldest expected word
  always @(negedge clk) begin : mon_a
    logic [15:0] e;
    if (!reset && ifa.out_valid) begin
      vcnt[0]++;
      if (rdy_v[0]) begin
        if (qa.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL a_unexpected_word: got %0h, expected no word", ifa.out_data);
        end else begin
          e = qa.pop_front();
          check("a_data", 32'(ifa.out_data), 32'(e));
        end
      end
    end
  end

  // Monitor B
  always @(negedge clk) begin : mon_b
    logic [7:0] e;
    if (!reset && ifb.out_valid) begin
      vcnt[1]++;
      if (rdy_v[1]) begin
        if (qb.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL b_unexpected_word: got %0h, expected no word", ifb.out_data);
        end else begin
          e = qb.pop_front();
          check("b_data", 32'(ifb.out_data), 32'(e));
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : stim
    int inst, nw, half;
    logic [31:0] w;

    sck_v[1] = 1'b1;
    rdy_v[0] = 1'b1;
    rdy_v[1] = 1'b1;
    repeat (3) tick();
    check("reset_data",  32'(ifa.out_data), 0);
    check("reset_valid", 32'(ifa.out_valid), 0);
    check("reset_ovr",   32'(ifa.overrun), 0);
    check("reset_bcnt",  32'(ifa.bit_count), 0);
    reset = 1'b0;
    repeat (4) tick();

    // LSB-first word, sck = clk/8
    vcnt[0] = 0;
    qa.push_back(16'hA5C3);
    frame_start(0);
    send_word(0, 32'hA5C3, 16, 4, 1'b0);
    frame_end(0);
    check("t1_valid_cycles", 32'(vcnt[0]), 1);
    check("t1_ovr", 32'(ifa.overrun), 0);

    // MSB-first, CPOL=1, two words in one frame
    qb.push_back(8'h3C);
    qb.push_back(8'h81);
    frame_start(1);
    send_word(1, 32'h3C, 3, 4, 1'b0);
    check("t2_bcnt_mid", 32'(ifb.bit_count), 3);
    send_word(1, 32'h3C << 3, 5, 4, 1'b0);
    check("t2_bcnt_w1", 32'(ifb.bit_count), 0);
    send_word(1, 32'h81, 8, 4, 1'b0);
    check("t2_bcnt_w2", 32'(ifb.bit_count), 0);
    frame_end(1);

    // Abort after 5 bits, then a clean frame
    frame_start(0);
    send_word(0, 32'hFFFF, 5, 4, 1'b0);
    check("t3_bcnt_partial", 32'(ifa.bit_count), 5);
    load_v[0] = 1'b0;
    repeat (4) tick();
    check("t3_bcnt_idle", 32'(ifa.bit_count), 0);
    qa.push_back(16'h1234);
    frame_start(0);
    send_word(0, 32'h1234, 16, 4, 1'b0);
    frame_end(0);

    // Backpressure: second word dropped, overrun sticky
    rdy_v[0] = 1'b0;
    qa.push_back(16'h1111);
    frame_start(0);
    send_word(0, 32'h1111, 16, 4, 1'b0);
    check("t4_ovr_first", 32'(ifa.overrun), 0);
    send_word(0, 32'h2222, 16, 4, 1'b0);
    frame_end(0);
    check("t4_data_held", 32'(ifa.out_data), 32'h1111);
    check("t4_valid", 32'(ifa.out_valid), 1);
    check("t4_ovr", 32'(ifa.overrun), 1);
    rdy_v[0] = 1'b1;
    tick();
    rdy_v[0] = 1'b0;
    check("t4_valid_after", 32'(ifa.out_valid), 0);
    check("t4_ovr_sticky", 32'(ifa.overrun), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t4_ovr_reset", 32'(ifa.overrun), 0);
    repeat (4) tick();

    // Transfer and completion in the same cycle
    qa.push_back(16'h1111);
    qa.push_back(16'h2222);
    frame_start(0);
    send_word(0, 32'h1111, 16, 4, 1'b0);
    check("t5_pending", 32'(ifa.out_valid), 1);
    send_word(0, 32'h2222, 16, 4, 1'b1);
    check("t5_data", 32'(ifa.out_data), 32'h2222);
    check("t5_valid", 32'(ifa.out_valid), 1);
    check("t5_ovr", 32'(ifa.overrun), 0);
    rdy_v[0] = 1'b1;
    repeat (3) tick();
    frame_end(0);

    // Reset mid-word with a word pending
    rdy_v[0] = 1'b0;
    frame_start(0);
    send_word(0, 32'hAAAA, 16, 4, 1'b0);
    send_word(0, 32'h5555, 9, 4, 1'b0);
    check("t6_valid_before", 32'(ifa.out_valid), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_data",  32'(ifa.out_data), 0);
    check("t6_valid", 32'(ifa.out_valid), 0);
    check("t6_ovr",   32'(ifa.overrun), 0);
    check("t6_bcnt",  32'(ifa.bit_count), 0);
    load_v[0] = 1'b0;
    sck_v[0]  = 1'b0;
    repeat (6) tick();
    rdy_v[0] = 1'b1;
    qa.push_back(16'h00F0);
    frame_start(0);
    send_word(0, 32'h00F0, 16, 4, 1'b0);
    frame_end(0);

    // Randomized frames on both instances, consumer always ready
    for (int f = 0; f < 24; f++) begin
      inst = int'($urandom_range(0, 1));
      nw   = int'($urandom_range(1, 3));
      half = int'($urandom_range(3, 6));
      frame_start(inst);
      for (int k = 0; k < nw; k++) begin
        w = $urandom;
        if (inst == 0) qa.push_back(w[15:0]);
        else           qb.push_back(w[7:0]);
        send_word(inst, w, width_c[inst], half, 1'b0);
        check("rnd_bcnt", inst == 0 ? 32'(ifa.bit_count) : 32'(ifb.bit_count), 0);
      end
      frame_end(inst);
    end

    repeat (6) tick();
    check("a_queue_drained", 32'(qa.size()), 0);
    check("b_queue_drained", 32'(qb.size()), 0);
    check("b_ovr_final", 32'(ifb.overrun), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_word_deserializer.md
# spi_word_deserializer

Parametrised SPI receive deserializer for the FPGA-side SPI link from the MCU. It oversamples the raw SPI pins (`sck`, `sdi`, `load`) in the `clk` domain and assembles `WIDTH`-bit words in a configurable bit order. It delivers each completed word through a valid/ready handshake with overrun detection. It replaces the fixed 16-bit, SPI-clocked shift register, and it supports back-to-back words within one `load` frame.

## Interface
Parameters:
- `WIDTH`, 16: word length in bits; must be ≥ 2.
- `LSB_FIRST`, 1: 1 means the first received bit lands in bit 0 (shift right); 0 means the first bit lands in bit `WIDTH-1` (shift left).
- `CPOL`, 0: 0 samples on the `sck` rising edge; 1 samples on the falling edge.

Ports:
- `clk` in 1: system clock. One clock domain for the whole block.
- `reset` in 1: synchronous, active-high reset.
- `sck` in 1: raw SPI clock, asynchronous to `clk`.
- `sdi` in 1: raw SPI data, asynchronous to `clk`.
- `load` in 1: raw frame enable, active-high. Low aborts any partial word.
- `out_data` out `WIDTH`: last completed word.
- `out_valid` out 1: `out_data` holds an unconsumed word.
- `out_ready` in 1: consumer accepts the word in the current cycle.
- `overrun` out 1: sticky flag; a completed word was dropped.
- `bit_count` out `$clog2(WIDTH)`: number of bits of the current partial word.

## Operation
- Synchronisation:
  - `sck`, `sdi` and `load` each pass through an identical 2-flop synchroniser, giving `sck_s`, `sdi_s` and `load_s`.
  - `sck_d` is `sck_s` delayed by one cycle.
  - The sample strobe is `sck_s & ~sck_d` when `CPOL`=0, and `~sck_s & sck_d` when `CPOL`=1.
- States:
  - IDLE is active whenever `load_s`=0. In IDLE, the shift register and `bit_count` are cleared to 0 every cycle and the strobe is ignored.
  - SHIFT is active whenever `load_s`=1.
- On a strobe in SHIFT:
  - With `LSB_FIRST`=1, the shift register becomes `{sdi_s, sr[WIDTH-1:1]}`.
  - With `LSB_FIRST`=0, it becomes `{sr[WIDTH-2:0], sdi_s}`.
  - `bit_count` increments.
- Word completion is a strobe while `bit_count`=`WIDTH-1`.
  - `bit_count` wraps to 0 and the block stays in SHIFT for the next word of the frame.
  - The completed word is the post-shift value. It goes to `out_data` on the same edge the shift takes effect.
- Handshake:
  - A transfer occurs in any cycle where `out_valid`=1 and `out_ready`=1.
  - `out_valid` clears after a transfer unless a word completes in the same cycle.
  - `out_data` holds its value while `out_valid`=0 and is not cleared on a transfer.
- Completion behaviour by case:
  - `out_valid`=0: load `out_data`, set `out_valid`.
  - `out_valid`=1 and `out_ready`=1: the old word transfers, the new word loads, `out_valid` stays 1, no overrun.
  - `out_valid`=1 and `out_ready`=0: the new word is dropped, `out_data` is unchanged, and `overrun` is set.
- `overrun` clears only on `reset`.
- `load` falling mid-word discards the partial bits. `out_data`, `out_valid` and `overrun` are unaffected.
- A strobe and `load_s` falling in the same cycle: `load_s`=0 takes priority, so no shift occurs.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `overrun`=0, `bit_count`=0. The shift register and synchroniser flops are also 0.
- `reset` mid-word or mid-frame: everything returns to reset values on the next edge. Reception restarts only after `load_s` has been observed low and then high again.
- Latency:
  - Call the first `clk` edge that samples a raw `sck` sampling transition edge 1. The shift occurs on edge 3.
  - `out_valid` rises on edge 3 of the final bit's `sck` edge.
  - `load` rise or fall takes effect on edge 3 after sampling, by the same path.
- Requirements on the external signals:
  - `sck` high and low phases must each last at least 3 `clk` periods.
  - `sdi` must be stable from 1 `clk` period before the sampling `sck` edge until 1 period after it, so that `sdi_s` is aligned with the strobe.
  - `load` must rise at least 3 `clk` periods before the first sampling edge.
- Sustained rate: one word per `WIDTH` `sck` periods. The consumer must assert `out_ready` within `WIDTH` × (`sck` period) after `out_valid` rises, or `overrun` will set.

## Test plan
- **LSB-first word.** `WIDTH`=16, `LSB_FIRST`=1, `CPOL`=0, `sck` = `clk`/8. Send 0xA5C3 LSB-first with `out_ready`=1 → `out_data`=0xA5C3; `out_valid` high for exactly 1 cycle; `overrun`=0.
- **MSB-first, inverted clock.** `WIDTH`=8, `LSB_FIRST`=0, `CPOL`=1. Send 0x3C MSB-first, then 0x81 in the same frame → two transfers, 0x3C then 0x81; `bit_count` returns to 0 after each.
- **Abort.** Drop `load` after 5 bits of 0xFFFF, then send a new frame carrying 0x1234 → only 0x1234 is delivered; `bit_count`=0 while `load_s`=0.
- **Backpressure.** Hold `out_ready`=0 and send 0x1111 then 0x2222 → `out_data` stays 0x1111; `overrun`=1 from the completion edge of 0x2222 and still 1 after `out_ready` pulses.
- **Simultaneous transfer and completion.** Assert `out_ready` exactly in the cycle 0x2222 completes while 0x1111 is pending → 0x1111 transfers, `out_data`=0x2222, `out_valid` stays 1, `overrun`=0.
- **Reset mid-operation.** Assert `reset` for 1 cycle after 9 bits with `out_valid`=1 → all outputs return to 0 on the next edge; a fresh frame carrying 0x00F0 yields exactly 0x00F0.
